// File: rtl/aes_round_engine_if.sv
// rtl/aes_round_engine_if.sv - Block-in / ciphertext-out / round-key-lookup bundle for aes_round_engine
interface aes_round_engine_if #(
    parameter int IDX_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic [IDX_W-1:0] rk_idx;
    logic [127:0]     rk_in;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;

    modport slave (
        input  in_valid, in_data, rk_in, out_ready,
        output in_ready, rk_idx, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, rk_in, out_ready,
        input  in_ready, rk_idx, out_valid, out_data
    );
endinterface

// File: rtl/aes_round_engine.sv
// rtl/aes_round_engine.sv - Iterative AES encryption engine, one round per clock (optional abort: AES_ABORT_EN)
module aes_round_engine #(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input  logic clk,
    input  logic rst_n,
`ifdef AES_ABORT_EN
    input  logic abort,
`endif
    output logic busy,
    aes_round_engine_if.slave bus
);

    generate
        if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
            $error("aes_round_engine: NR must be 10, 12 or 14");
        end
        if ((1 << IDX_W) <= NR) begin : g_bad_idx_w
            $error("aes_round_engine: IDX_W too narrow for NR");
        end
    endgenerate

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] RND_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] RND_LAST = IDX_W'(NR);

    // Forward S-box, entry x at bits [2047-8x -: 8]
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8 * i -: 8] = sbox(s[127 - 8 * i -: 8]);
        end
        return r;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127 - 8 * (4 * c + w) -: 8] = s[127 - 8 * (4 * ((c + w) % 4) + w) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            r[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    logic [1:0]       fsm;
    logic [IDX_W-1:0] round;
    logic [127:0]     state_q;
    logic [127:0]     out_q;
    logic [127:0]     sr_w;
    logic [127:0]     full_w;
    logic [127:0]     final_w;
    logic             abort_req;

`ifdef AES_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign sr_w    = shift_rows(sub_bytes(state_q));
    assign full_w  = mix_columns(sr_w) ^ bus.rk_in;
    assign final_w = sr_w ^ bus.rk_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm     <= S_IDLE;
            round   <= '0;
            state_q <= '0;
            out_q   <= '0;
        end else if (abort_req && fsm != S_IDLE) begin
            fsm   <= S_IDLE;
            round <= '0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        state_q <= bus.in_data ^ bus.rk_in;
                        round   <= RND_ONE;
                        fsm     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (round == RND_LAST) begin
                        state_q <= final_w;
                        out_q   <= final_w;
                        fsm     <= S_DONE;
                    end else begin
                        state_q <= full_w;
                        round   <= round + RND_ONE;
                    end
                end
                S_DONE: begin
                    // No bypass into IDLE: the next block is accepted one cycle after handoff.
                    if (bus.out_ready) begin
                        fsm   <= S_IDLE;
                        round <= '0;
                    end
                end
                default: begin
                    fsm   <= S_IDLE;
                    round <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (fsm == S_IDLE);
    assign bus.out_valid = (fsm == S_DONE);
    assign bus.out_data  = out_q;
    assign bus.rk_idx    = (fsm == S_RUN) ? round : '0;
    assign busy          = (fsm == S_RUN);

endmodule

// File: doc/aes_round_engine.md
Name: aes_round_engine

Overview:
- Iterative AES encryption datapath. Executes the initial AddRoundKey, NR−1 full rounds, and the final round (SubBytes, ShiftRows, AddRoundKey, no MixColumns) on a single shared round datapath, one round per clock.
- Parametrised successor of the fixed final-round unit. It covers AES-128, AES-192 and AES-256 through NR, adds a valid/ready handshake, and requests round keys by index.
- Sits between the block-mode controller (upstream) and the key-schedule store, which supplies rk_in combinationally from rk_idx.

Parameters:
- NR, 10, number of rounds. Legal values are 10, 12 and 14. Any other value is a elaboration error ($error).
- IDX_W, 4, width of rk_idx. Must satisfy 2^IDX_W > NR.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  plaintext block valid
- in_ready  out  1  engine can accept a block
- in_data  in  128  plaintext, byte 0 in [127:120]
- rk_idx  out  IDX_W  round-key index currently required
- rk_in  in  128  round key for rk_idx, same cycle (combinational lookup)
- out_valid  out  1  ciphertext valid
- out_ready  in  1  downstream accepts ciphertext
- out_data  out  128  ciphertext
- busy  out  1  engine is in RUN

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - state register = 0, round counter = 0, FSM = IDLE
  - in_ready = 1, out_valid = 0, busy = 0, out_data = 0, rk_idx = 0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, rk_idx = 0.
  - On in_valid & in_ready: state <= in_data ^ rk_in, round <= 1, go to RUN.
- RUN:
  - in_ready = 0, busy = 1, rk_idx = round.
  - round < NR: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk_in, round <= round + 1.
  - round == NR: state <= ShiftRows(SubBytes(state)) ^ rk_in, go to DONE.
- DONE:
  - out_valid = 1, out_data = state, held stable until out_ready.
  - On out_valid & out_ready: go to IDLE, out_valid deasserts next cycle.
  - No bypass: a new block cannot be accepted in the same cycle as output handoff. in_ready rises the cycle after handoff.
- Latency:
  - Accept at cycle 0 → out_valid high at cycle NR+1.
  - Throughput is one block per NR+2 cycles when out_ready is held high.
- Datapath rules:
  - SubBytes uses the forward S-box and is combinational inside the block.
  - MixColumns uses GF(2^8) xtime with reduction polynomial 0x11B.
  - ShiftRows uses column-major byte order per FIPS-197.
- Boundary conditions:
  - in_valid while busy is ignored. in_data is not sampled.
  - out_ready asserted when out_valid = 0 has no effect.
  - rk_in is sampled only on the RUN/IDLE accept edge. Its value at other times is don't-care.
  - Round counter never exceeds NR and does not wrap.
  - rst_n asserted mid-RUN or mid-DONE: immediate return to the reset values. The in-flight block is discarded and no partial out_valid is produced.
  - out_data remains 0 until the first completion. After handoff it retains the last ciphertext, but it is valid only when out_valid = 1.

Optional Feature:
- Macro: AES_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort = 1 in RUN or DONE forces FSM to IDLE on the next edge and clears the round counter. No out_valid is generated for the aborted block.
  - abort in IDLE is ignored. abort has priority over a simultaneous out_ready handoff in DONE.
- Undefined: no abort port; FSM behaviour exactly as above.

Test Plan:
- NR=10, key 2b7e151628aed2a6abf7158809cf4f3c (bench supplies expanded keys by rk_idx), pt 3243f6a8885a308d313198a2e0370734 → out_data 3925841d02dc09fbdc118597196a0b32, out_valid at cycle 11 after accept.
- NR=10, key 000102…0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a. NR=14 with key 000102…1f → 8ea2b7ca516745bfeafc49904b496089 at cycle 15.
- Backpressure: out_ready = 0 for 20 cycles after out_valid → out_data stable, in_ready = 0, in_valid pulses ignored. Release → in_ready = 1 next cycle.
- Back-to-back: in_valid and out_ready held high, 4 blocks → each accepted every NR+2 cycles, ciphertexts in order and matching the reference model.
- Reset mid-RUN at round 5 → all outputs at reset values immediately. Next block encrypts correctly with no residue.
- AES_ABORT_EN: abort at round 3 → IDLE next cycle, no out_valid. abort together with out_ready in DONE → block dropped, out_valid falls.
